// File: rtl/pulsadores_acond.sv
// Push-button conditioning: two-flop synchroniser, debounce and press pulse per button.
// Define AUTOREPEAT_EN to add hold-to-repeat on the four direction buttons.
`timescale 1ns/1ps
module pulsadores_acond #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int REP_DELAY  = 50_000_000,
    parameter int REP_RATE   = 10_000_000,
    parameter int CW         = 27
) (
    input  logic clk,
    input  logic Reset,
    input  logic push_izquierda,
    input  logic push_derecha,
    input  logic push_arriba,
    input  logic push_abajo,
    input  logic push_centro,
    output logic nivel_izq,
    output logic nivel_der,
    output logic nivel_arr,
    output logic nivel_aba,
    output logic nivel_cen,
    output logic pulso_izq,
    output logic pulso_der,
    output logic pulso_arr,
    output logic pulso_aba,
    output logic pulso_cen,
    output logic pulso_any
);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(REP_DELAY - 1);
    localparam logic [CW-1:0] RTE_LAST = CW'(REP_RATE - 1);

    if (DEB_CYCLES < 2 || REP_DELAY < 1 || REP_RATE < 1 ||
        ((DEB_CYCLES - 1) >> CW) != 0 || ((REP_DELAY - 1) >> CW) != 0 ||
        ((REP_RATE - 1) >> CW) != 0) begin : g_param_check
        $error("pulsadores_acond: illegal DEB_CYCLES/REP_DELAY/REP_RATE/CW combination");
    end

    // Channel index: 0 left, 1 right, 2 up, 3 down, 4 center.
    logic [4:0]    raw_s;
    logic [4:0]    s1_q, s2_q;
    logic [4:0]    level_q, level_d;
    logic [4:0]    pulse_s;
    logic [CW-1:0] deb_cnt_q [5];
    logic [CW-1:0] deb_cnt_d [5];

    assign raw_s = {push_centro, push_abajo, push_arriba, push_derecha, push_izquierda};

    // Debounce: level flips only after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            level_d[i]   = level_q[i];
            deb_cnt_d[i] = CNT_ZERO;
            if (s2_q[i] != level_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    level_d[i]   = ~level_q[i];
                    deb_cnt_d[i] = CNT_ZERO;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CNT_ONE;
                end
            end else begin
                deb_cnt_d[i] = CNT_ZERO;
            end
        end
    end

    // Synchroniser, debounce counters and stored levels.
    always_ff @(posedge clk) begin
        if (Reset) begin
            s1_q    <= 5'b00000;
            s2_q    <= 5'b00000;
            level_q <= 5'b00000;
            for (int i = 0; i < 5; i++) begin
                deb_cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            s1_q    <= raw_s;
            s2_q    <= s1_q;
            level_q <= level_d;
            for (int i = 0; i < 5; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < 5; g++) begin : g_ch
`ifdef AUTOREPEAT_EN
        localparam bit HAS_REP = (g < 4);
`else
        localparam bit HAS_REP = 1'b0;
`endif
        logic rise_s;
        logic pulse_q;

        assign rise_s     = level_d[g] & ~level_q[g];
        assign pulse_s[g] = pulse_q;

        if (HAS_REP) begin : g_rep
            typedef enum logic [1:0] {
                ST_IDLE   = 2'd0,
                ST_WAIT   = 2'd1,
                ST_REPEAT = 2'd2
            } rep_state_t;

            rep_state_t    state_q, state_d;
            logic [CW-1:0] rep_cnt_q, rep_cnt_d;
            logic          fall_s;
            logic          pulse_d;

            assign fall_s = level_q[g] & ~level_d[g];

            // Repeat FSM state and counter registers.
            always_ff @(posedge clk) begin
                if (Reset) begin
                    state_q   <= ST_IDLE;
                    rep_cnt_q <= CNT_ZERO;
                    pulse_q   <= 1'b0;
                end else begin
                    state_q   <= state_d;
                    rep_cnt_q <= rep_cnt_d;
                    pulse_q   <= pulse_d;
                end
            end

            // Next state: a falling level aborts from any state.
            always_comb begin
                state_d   = state_q;
                rep_cnt_d = CNT_ZERO;
                if (fall_s) begin
                    state_d   = ST_IDLE;
                    rep_cnt_d = CNT_ZERO;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (rise_s) begin
                                state_d = ST_WAIT;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                        ST_WAIT: begin
                            if (rep_cnt_q == DLY_LAST) begin
                                state_d = ST_REPEAT;
                            end else begin
                                rep_cnt_d = rep_cnt_q + CNT_ONE;
                            end
                        end
                        ST_REPEAT: begin
                            if (rep_cnt_q == RTE_LAST) begin
                                rep_cnt_d = CNT_ZERO;
                            end else begin
                                rep_cnt_d = rep_cnt_q + CNT_ONE;
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end

            // Pulse output: press edge, end of delay, or end of each repeat period.
            always_comb begin
                pulse_d = 1'b0;
                if (fall_s) begin
                    pulse_d = 1'b0;
                end else begin
                    case (state_q)
                        ST_IDLE:   pulse_d = rise_s;
                        ST_WAIT:   pulse_d = (rep_cnt_q == DLY_LAST);
                        ST_REPEAT: pulse_d = (rep_cnt_q == RTE_LAST);
                        default:   pulse_d = 1'b0;
                    endcase
                end
            end
        end else begin : g_norep
            // One pulse per accepted press, nothing on release.
            always_ff @(posedge clk) begin
                if (Reset) begin
                    pulse_q <= 1'b0;
                end else begin
                    pulse_q <= rise_s;
                end
            end
        end
    end

    assign nivel_izq = level_q[0];
    assign nivel_der = level_q[1];
    assign nivel_arr = level_q[2];
    assign nivel_aba = level_q[3];
    assign nivel_cen = level_q[4];
    assign pulso_izq = pulse_s[0];
    assign pulso_der = pulse_s[1];
    assign pulso_arr = pulse_s[2];
    assign pulso_aba = pulse_s[3];
    assign pulso_cen = pulse_s[4];
    assign pulso_any = |pulse_s;

endmodule
